// File: rtl/i2c_bus_monitor_if.sv
// Pad-side inputs and filtered/decoded outputs of the I2C bus monitor.
// The monitor itself uses the master modport; the consumer uses slave.
interface i2c_bus_monitor_if;
  logic scl_pad_i;
  logic sda_pad_i;
  logic scl_o;
  logic sda_o;
  logic scl_rise_o;
  logic scl_fall_o;
  logic start_o;
  logic stop_o;
  logic busy_o;

  modport master (
    input  scl_pad_i,
    input  sda_pad_i,
    output scl_o,
    output sda_o,
    output scl_rise_o,
    output scl_fall_o,
    output start_o,
    output stop_o,
    output busy_o
  );

  modport slave (
    output scl_pad_i,
    output sda_pad_i,
    input  scl_o,
    input  sda_o,
    input  scl_rise_o,
    input  scl_fall_o,
    input  start_o,
    input  stop_o,
    input  busy_o
  );
endinterface

// File: rtl/i2c_bus_monitor.sv
// I2C bus monitor: synchronizes and glitch-filters SCL/SDA, then decodes
// SCL edges, START/STOP conditions and the bus-busy state from the filtered lines.
module i2c_bus_monitor #(
  parameter int unsigned FILT_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [FILT_W-1:0] filt_len_i,
  i2c_bus_monitor_if.master bus
);

  localparam int unsigned LINE_SCL = 0;
  localparam int unsigned LINE_SDA = 1;
  localparam logic [FILT_W-1:0] CNT_MAX = '1;
  localparam logic [FILT_W-1:0] CNT_ONE = FILT_W'(1);

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_e;

  logic [1:0]        meta_q, meta_d;
  logic [1:0]        sync_q, sync_d;
  logic [1:0]        filt_q, filt_d;
  logic [FILT_W-1:0] cnt_q [2];
  logic [FILT_W-1:0] cnt_d [2];

  logic scl_rise_q, scl_rise_d;
  logic scl_fall_q, scl_fall_d;
  logic start_q, start_d;
  logic stop_q, stop_d;
  logic scl_stable_hi;

  state_e state_q, state_d;

  always_comb begin
    meta_d = {bus.sda_pad_i, bus.scl_pad_i};
    sync_d = meta_q;
  end

  // A line only moves once the synchronized value has disagreed with the
  // filtered value for more than filt_len_i consecutive cycles.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      cnt_d[i]  = '0;
      if (!en_i) begin
        filt_d[i] = 1'b1;
        cnt_d[i]  = '0;
      end else if (sync_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= filt_len_i) begin
        filt_d[i] = sync_q[i];
        cnt_d[i]  = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i] = cnt_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_comb begin
    scl_stable_hi = filt_q[LINE_SCL] & filt_d[LINE_SCL];
    scl_rise_d    = en_i & ~filt_q[LINE_SCL] &  filt_d[LINE_SCL];
    scl_fall_d    = en_i &  filt_q[LINE_SCL] & ~filt_d[LINE_SCL];
    start_d       = en_i & scl_stable_hi &  filt_q[LINE_SDA] & ~filt_d[LINE_SDA];
    stop_d        = en_i & scl_stable_hi & ~filt_q[LINE_SDA] &  filt_d[LINE_SDA];
  end

  // Busy follows the registered START/STOP pulses, so it changes one cycle
  // after the pulse is visible.
  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = ST_IDLE;
    end else if (start_q) begin
      state_d = ST_BUSY;
    end else if (stop_q) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q     <= 2'b11;
      sync_q     <= 2'b11;
      filt_q     <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= '0;
      end
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      filt_q     <= filt_d;
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      state_q    <= state_d;
    end
  end

  assign bus.scl_o      = filt_q[LINE_SCL];
  assign bus.sda_o      = filt_q[LINE_SDA];
  assign bus.scl_rise_o = scl_rise_q;
  assign bus.scl_fall_o = scl_fall_q;
  assign bus.start_o    = start_q;
  assign bus.stop_o     = stop_q;
  assign bus.busy_o     = (state_q == ST_BUSY);

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Scoreboard bench for i2c_bus_monitor: stimulus queues the expected pulse
// and its cycle, a negedge monitor pops and compares whenever a pulse appears.
module tb_i2c_bus_monitor;

  localparam int FILT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [FILT_W-1:0] filt_len;

  i2c_bus_monitor_if bus_if ();

  i2c_bus_monitor #(.FILT_W(FILT_W)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .filt_len_i (filt_len),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum logic [1:0] {EV_RISE, EV_FALL, EV_START, EV_STOP} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    int unsigned at;
  } ev_t;

  ev_t exp_q[$];
  int  check_cnt = 0;
  int  pass_cnt  = 0;

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    check_cnt++;
    if (actual === expected) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic scl, input logic sda);
    bus_if.scl_pad_i = scl;
    bus_if.sda_pad_i = sda;
  endtask

  task automatic expectEvent(input ev_kind_e kind, input int unsigned delay);
    ev_t e;
    e.kind = kind;
    e.at   = cyc + delay;
    exp_q.push_back(e);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every visible pulse must match the head of the queue in kind
  // and cycle; an expected pulse that has gone overdue is reported missing.
  logic [3:0] pulses;
  logic [3:0] want;
  ev_t        exp_ev;
  always @(negedge clk) begin
    pulses = {bus_if.stop_o, bus_if.start_o, bus_if.scl_fall_o, bus_if.scl_rise_o};
    if (exp_q.size() != 0 && exp_q[0].at < cyc) begin
      check_cnt++;
      $display("[TB] FAIL missing_%s: no pulse seen, required at cycle %0d (now %0d)",
               exp_q[0].kind.name(), exp_q[0].at, cyc);
      void'(exp_q.pop_front());
    end
    if (pulses != 4'b0000) begin
      check_cnt++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL unexpected_pulse: got pulses %b at cycle %0d, required none", pulses, cyc);
      end else begin
        exp_ev = exp_q.pop_front();
        want   = 4'b0001 << exp_ev.kind;
        if (pulses == want && cyc == exp_ev.at) begin
          pass_cnt++;
        end else begin
          $display("[TB] FAIL pulse_%s: got pulses %b at cycle %0d, required %b at cycle %0d",
                   exp_ev.kind.name(), pulses, cyc, want, exp_ev.at);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    filt_len = 4'd4;
    applyStimulus(1'b1, 1'b1);
    #12;
    checkOutput("reset_scl", bus_if.scl_o, 1'b1);
    checkOutput("reset_sda", bus_if.sda_o, 1'b1);
    checkOutput("reset_busy", bus_if.busy_o, 1'b0);
    checkOutput("reset_start", bus_if.start_o, 1'b0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(3);

    $display("[TB] latency, filt_len=4");
    applyStimulus(1'b0, 1'b1);
    expectEvent(EV_FALL, 7);
    waitCycles(6);
    checkOutput("lat_scl_before", bus_if.scl_o, 1'b0 ^ 1'b1);
    waitCycles(1);
    checkOutput("lat_scl_after", bus_if.scl_o, 1'b0);
    checkOutput("lat_fall_pulse", bus_if.scl_fall_o, 1'b1);
    waitCycles(1);
    checkOutput("lat_fall_single", bus_if.scl_fall_o, 1'b0);
    applyStimulus(1'b1, 1'b1);
    expectEvent(EV_RISE, 7);
    waitCycles(10);

    $display("[TB] glitch, filt_len=3");
    filt_len = 4'd3;
    applyStimulus(1'b1, 1'b0);
    waitCycles(3);
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      waitCycles(1);
      checkOutput("glitch_sda", bus_if.sda_o, 1'b1);
    end

    $display("[TB] transfer, filt_len=2");
    filt_len = 4'd2;
    waitCycles(2);
    applyStimulus(1'b1, 1'b0);
    expectEvent(EV_START, 5);
    waitCycles(5);
    checkOutput("xfer_start", bus_if.start_o, 1'b1);
    checkOutput("xfer_busy_pre", bus_if.busy_o, 1'b0);
    waitCycles(1);
    checkOutput("xfer_busy_set", bus_if.busy_o, 1'b1);
    waitCycles(4);
    applyStimulus(1'b1, 1'b1);
    expectEvent(EV_STOP, 5);
    waitCycles(5);
    checkOutput("xfer_stop", bus_if.stop_o, 1'b1);
    checkOutput("xfer_busy_hold", bus_if.busy_o, 1'b1);
    waitCycles(1);
    checkOutput("xfer_busy_clr", bus_if.busy_o, 1'b0);
    waitCycles(4);

    $display("[TB] simultaneous edges and STOP while idle");
    applyStimulus(1'b0, 1'b0);
    expectEvent(EV_FALL, 5);
    waitCycles(8);
    checkOutput("same_cycle_busy", bus_if.busy_o, 1'b0);
    applyStimulus(1'b1, 1'b0);
    expectEvent(EV_RISE, 5);
    waitCycles(8);
    applyStimulus(1'b1, 1'b1);
    expectEvent(EV_STOP, 5);
    waitCycles(5);
    checkOutput("idle_stop_busy", bus_if.busy_o, 1'b0);
    waitCycles(1);
    checkOutput("idle_stop_busy_after", bus_if.busy_o, 1'b0);
    waitCycles(3);

    $display("[TB] repeated START");
    applyStimulus(1'b1, 1'b0);
    expectEvent(EV_START, 5);
    waitCycles(8);
    applyStimulus(1'b0, 1'b0);
    expectEvent(EV_FALL, 5);
    waitCycles(8);
    applyStimulus(1'b0, 1'b1);
    waitCycles(8);
    applyStimulus(1'b1, 1'b1);
    expectEvent(EV_RISE, 5);
    waitCycles(8);
    applyStimulus(1'b1, 1'b0);
    expectEvent(EV_START, 5);
    waitCycles(5);
    checkOutput("rstart_pulse", bus_if.start_o, 1'b1);
    checkOutput("rstart_busy", bus_if.busy_o, 1'b1);
    waitCycles(1);
    checkOutput("rstart_busy_hold", bus_if.busy_o, 1'b1);
    waitCycles(4);

    $display("[TB] enable drop and reassert, filt_len=4");
    filt_len = 4'd4;
    waitCycles(2);
    applyStimulus(1'b0, 1'b0);
    waitCycles(4);
    en = 1'b0;
    waitCycles(2);
    checkOutput("en_off_scl", bus_if.scl_o, 1'b1);
    checkOutput("en_off_sda", bus_if.sda_o, 1'b1);
    checkOutput("en_off_busy", bus_if.busy_o, 1'b0);
    waitCycles(3);
    en = 1'b1;
    expectEvent(EV_FALL, 5);
    waitCycles(1);
    checkOutput("en_on_scl", bus_if.scl_o, 1'b1);
    checkOutput("en_on_sda", bus_if.sda_o, 1'b1);
    waitCycles(4);
    checkOutput("en_on_scl_fell", bus_if.scl_o, 1'b0);
    waitCycles(3);
    applyStimulus(1'b1, 1'b1);
    expectEvent(EV_RISE, 7);
    waitCycles(10);

    $display("[TB] reset while busy and mid-filter, filt_len=2");
    filt_len = 4'd2;
    applyStimulus(1'b1, 1'b0);
    expectEvent(EV_START, 5);
    waitCycles(7);
    checkOutput("rst_pre_busy", bus_if.busy_o, 1'b1);
    applyStimulus(1'b0, 1'b0);
    waitCycles(2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy_clear", bus_if.busy_o, 1'b0);
    waitCycles(2);
    rst_n = 1'b1;
    expectEvent(EV_FALL, 5);
    waitCycles(1);
    checkOutput("rst_first_scl", bus_if.scl_o, 1'b1);
    checkOutput("rst_first_busy", bus_if.busy_o, 1'b0);
    waitCycles(7);
    applyStimulus(1'b1, 1'b1);
    expectEvent(EV_RISE, 5);
    waitCycles(8);

    $display("[TB] filt_len lowered mid-count");
    filt_len = 4'd15;
    applyStimulus(1'b0, 1'b1);
    waitCycles(8);
    filt_len = 4'd3;
    expectEvent(EV_FALL, 1);
    waitCycles(1);
    checkOutput("lenchg_fall", bus_if.scl_fall_o, 1'b1);
    waitCycles(4);
    applyStimulus(1'b1, 1'b1);
    expectEvent(EV_RISE, 6);
    waitCycles(9);

    $display("[TB] saturation, filt_len=15");
    filt_len = 4'd15;
    applyStimulus(1'b0, 1'b1);
    expectEvent(EV_FALL, 18);
    waitCycles(20);
    checkOutput("sat_scl", bus_if.scl_o, 1'b0);
    applyStimulus(1'b1, 1'b1);
    expectEvent(EV_RISE, 18);
    waitCycles(22);
    checkOutput("sat_scl_back", bus_if.scl_o, 1'b1);

    waitCycles(5);
    checkOutput("queue_drained", exp_q.size() == 0, 1'b1);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
